// File: rtl/datapath_issue_queue.sv
// Issue queue feeding the arithmetic datapath: buffers operand triples, issues
// at most one per cycle and re-joins each datapath result with its opcode.
module datapath_issue_queue #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_A,
    input  logic [N-1:0] in_B,
    input  logic [2:0]   in_opcode,
    input  logic         pipe_req,
    output logic [N-1:0] dp_A,
    output logic [N-1:0] dp_B,
    output logic [2:0]   dp_opcode,
    output logic         dp_pipe,
    input  logic [N-1:0] dp_Y,
    input  logic         dp_co,
    output logic         out_valid,
    output logic [N-1:0] out_Y,
    output logic         out_co,
    output logic [2:0]   out_opcode,
    output logic         busy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned NS = LAT + 1;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
    } entry_t;

    typedef struct packed {
        logic       v;
        logic [2:0] op;
    } tag_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pipe_q, pipe_d;
    tag_t          tag_q [NS];
    tag_t          tag_d [NS];
    entry_t        dp_q, dp_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_Y_q, out_Y_d;
    logic          out_co_q, out_co_d;
    logic [2:0]    out_op_q, out_op_d;

    logic          push, issue, in_flight;
    tag_t          final_tag;
    entry_t        head;

    always_comb begin
        in_flight = 1'b0;
        for (int unsigned i = 0; i < NS; i++) begin
            in_flight = in_flight | tag_q[i].v;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign in_ready  = (count_q != CW'(DEPTH)) && !rst;
    assign push      = in_valid && in_ready;
    assign issue     = (count_q != '0) && (pipe_q == pipe_req);
    assign final_tag = pipe_q ? tag_q[NS-1] : tag_q[0];
    assign busy      = (count_q != '0) || in_flight;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pipe_d      = pipe_q;
        dp_d        = dp_q;
        out_valid_d = final_tag.v;
        out_Y_d     = out_Y_q;
        out_co_d    = out_co_q;
        out_op_d    = out_op_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            dp_d     = head;
        end
        if (push && !issue) count_d = count_q + CW'(1);
        else if (!push && issue) count_d = count_q - CW'(1);

        // Mode only flips once the tag pipe is empty, so the stage count never
        // changes underneath an operation in flight.
        if ((pipe_req != pipe_q) && !in_flight) pipe_d = pipe_req;

        tag_d[0].v  = issue;
        tag_d[0].op = head.op;
        for (int unsigned i = 1; i < NS; i++) begin
            tag_d[i] = pipe_q ? tag_q[i-1] : '0;
        end

        if (final_tag.v) begin
            out_Y_d  = dp_Y;
            out_co_d = dp_co;
            out_op_d = final_tag.op;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_A, in_B, in_opcode};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pipe_q      <= 1'b0;
            dp_q        <= '0;
            out_valid_q <= 1'b0;
            out_Y_q     <= '0;
            out_co_q    <= 1'b0;
            out_op_q    <= '0;
            for (int unsigned i = 0; i < NS; i++) tag_q[i] <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pipe_q      <= pipe_d;
            dp_q        <= dp_d;
            out_valid_q <= out_valid_d;
            out_Y_q     <= out_Y_d;
            out_co_q    <= out_co_d;
            out_op_q    <= out_op_d;
            for (int unsigned i = 0; i < NS; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign dp_A       = dp_q.a;
    assign dp_B       = dp_q.b;
    assign dp_opcode  = dp_q.op;
    assign dp_pipe    = pipe_q;
    assign out_valid  = out_valid_q;
    assign out_Y      = out_Y_q;
    assign out_co     = out_co_q;
    assign out_opcode = out_op_q;
endmodule

// File: tb/tb_datapath_issue_queue.sv
// Bench for datapath_issue_queue: a stub datapath, a queue-based transaction
// model compared every cycle, directed scenarios and a random scoreboard run.
module tb_datapath_issue_queue;
    localparam int unsigned N     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 2;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
    } trip_t;

    typedef struct {
        trip_t t;
        int    rem;
    } flight_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_A = '0;
    logic [N-1:0] in_B = '0;
    logic [2:0]   in_opcode = '0;
    logic         pipe_req = 1'b0;
    logic [N-1:0] dp_A, dp_B;
    logic [2:0]   dp_opcode;
    logic         dp_pipe;
    logic [N-1:0] dp_Y;
    logic         dp_co;
    logic         out_valid;
    logic [N-1:0] out_Y;
    logic         out_co;
    logic [2:0]   out_opcode;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    datapath_issue_queue #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_opcode(in_opcode),
        .pipe_req(pipe_req),
        .dp_A(dp_A), .dp_B(dp_B), .dp_opcode(dp_opcode), .dp_pipe(dp_pipe),
        .dp_Y(dp_Y), .dp_co(dp_co),
        .out_valid(out_valid), .out_Y(out_Y), .out_co(out_co), .out_opcode(out_opcode),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N:0] dp_func(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a[0], a[N-1], a[N-1:1]};
            default: return {1'b0, b};
        endcase
    endfunction

    // Stub datapath: combinational, or two register stages when dp_pipe=1.
    logic [N:0] s1 = '0, s2 = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= dp_func(dp_A, dp_B, dp_opcode);
            s2 <= s1;
        end
    end
    assign {dp_co, dp_Y} = dp_pipe ? s2 : dp_func(dp_A, dp_B, dp_opcode);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction model: FIFO queue, in-flight list with countdowns, mode bit.
    trip_t        fq[$];
    flight_t      fl[$];
    trip_t        acc_log[$];
    logic [N+3:0] res_log[$];
    logic         mpipe = 1'b0;
    logic [N-1:0] e_dpA = '0, e_dpB = '0, e_Y = '0;
    logic [2:0]   e_dpop = '0, e_op = '0;
    logic         e_ov = 1'b0, e_co = 1'b0;
    logic         m_push, m_issue, m_idle, m_oldpipe;
    trip_t        m_t;
    flight_t      m_f;
    logic [N:0]   m_r;

    // Inputs change only at negedge+1, so at the negedge they still hold the
    // values the preceding rising edge sampled.
    always @(negedge clk) begin
        if (rst) begin
            fq.delete();
            fl.delete();
            mpipe = 1'b0;
            e_dpA = '0; e_dpB = '0; e_dpop = '0;
            e_ov = 1'b0; e_Y = '0; e_co = 1'b0; e_op = '0;
        end else begin
            m_push    = in_valid && (fq.size() < DEPTH);
            m_issue   = (fq.size() != 0) && (mpipe == pipe_req);
            m_idle    = (fl.size() == 0);
            m_oldpipe = mpipe;
            e_ov      = 1'b0;
            foreach (fl[i]) fl[i].rem--;
            if (fl.size() != 0 && fl[0].rem == 0) begin
                m_f  = fl.pop_front();
                m_r  = dp_func(m_f.t.a, m_f.t.b, m_f.t.op);
                e_ov = 1'b1;
                e_Y  = m_r[N-1:0];
                e_co = m_r[N];
                e_op = m_f.t.op;
            end
            if (pipe_req != mpipe && m_idle) mpipe = pipe_req;
            if (m_issue) begin
                m_t    = fq.pop_front();
                e_dpA  = m_t.a;
                e_dpB  = m_t.b;
                e_dpop = m_t.op;
                m_f.t  = m_t;
                m_f.rem = m_oldpipe ? int'(LAT) + 1 : 1;
                fl.push_back(m_f);
            end
            if (m_push) begin
                m_t.a  = in_A;
                m_t.b  = in_B;
                m_t.op = in_opcode;
                fq.push_back(m_t);
                acc_log.push_back(m_t);
            end
        end

        chk("in_ready", 32'(in_ready), 32'(!rst && (fq.size() < DEPTH)));
        chk("busy", 32'(busy), 32'((fq.size() != 0) || (fl.size() != 0)));
        chk("dp_A", 32'(dp_A), 32'(e_dpA));
        chk("dp_B", 32'(dp_B), 32'(e_dpB));
        chk("dp_opcode", 32'(dp_opcode), 32'(e_dpop));
        chk("dp_pipe", 32'(dp_pipe), 32'(mpipe));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("out_Y", 32'(out_Y), 32'(e_Y));
        chk("out_co", 32'(out_co), 32'(e_co));
        chk("out_opcode", 32'(out_opcode), 32'(e_op));
        if (out_valid && !rst) res_log.push_back({out_opcode, out_co, out_Y});
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] op);
        in_valid  = v;
        in_A      = a;
        in_B      = b;
        in_opcode = op;
    endtask

    task automatic wait_out(input string name, input int bound);
        int waited;
        waited = 0;
        do begin
            step();
            waited++;
        end while (!out_valid && waited < bound);
        chk(name, 32'(out_valid), 32'(1));
    endtask

    task automatic wait_idle(input string name, input int bound);
        int waited;
        waited = 0;
        while ((busy || fq.size() != 0 || fl.size() != 0) && waited < bound) begin
            step();
            waited++;
        end
        chk(name, 32'(busy), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int guard;
        int exp3 [6];
        logic [N:0] r;
        exp3 = '{30, 1001, 1002, 1003, 1004, 1005};

        // Reset
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_dp_pipe", 32'(dp_pipe), 32'(0));
        rst = 1'b0;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'(1));

        // Single op, combinational mode
        drive(1'b1, 16'd5, 16'hFFFD, 3'd0);
        step();
        c0 = cyc;
        drive(1'b0, '0, '0, '0);
        wait_out("t1_timeout", 20);
        chk("t1_latency", 32'(cyc - c0), 32'(2));
        chk("t1_Y", 32'(out_Y), 32'(16'd2));
        chk("t1_co", 32'(out_co), 32'(1));
        chk("t1_opcode", 32'(out_opcode), 32'(0));

        // Back-to-back, pipelined mode
        pipe_req = 1'b1;
        step();
        step();
        chk("t2_dp_pipe", 32'(dp_pipe), 32'(1));
        drive(1'b1, 16'd1, 16'd1, 3'd0);
        step();
        c0 = cyc;
        drive(1'b1, 16'd2, 16'd2, 3'd0);
        step();
        drive(1'b1, 16'd3, 16'd3, 3'd0);
        step();
        drive(1'b1, 16'h7FFF, 16'd1, 3'd0);
        step();
        drive(1'b0, '0, '0, '0);
        wait_out("t2_timeout", 20);
        chk("t2_latency", 32'(cyc - c0), 32'(4));
        chk("t2_Y0", 32'(out_Y), 32'(16'd2));
        step();
        chk("t2_v1", 32'(out_valid), 32'(1));
        chk("t2_Y1", 32'(out_Y), 32'(16'd4));
        step();
        chk("t2_v2", 32'(out_valid), 32'(1));
        chk("t2_Y2", 32'(out_Y), 32'(16'd6));
        step();
        chk("t2_v3", 32'(out_valid), 32'(1));
        chk("t2_Y3", 32'(out_Y), 32'(16'h8000));
        chk("t2_co3", 32'(out_co), 32'(0));
        step();
        chk("t2_done", 32'(out_valid), 32'(0));

        // Full, wrap and mode switch with a tag in flight
        res_log.delete();
        drive(1'b1, 16'd10, 16'd20, 3'd0);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        pipe_req = 1'b0;
        drive(1'b1, 16'd1, 16'd1000, 3'd0);
        step();
        drive(1'b1, 16'd2, 16'd1000, 3'd0);
        step();
        drive(1'b1, 16'd3, 16'd1000, 3'd0);
        step();
        chk("t3_x_valid", 32'(out_valid), 32'(1));
        chk("t3_x_Y", 32'(out_Y), 32'(16'd30));
        chk("t3_pipe_before", 32'(dp_pipe), 32'(1));
        drive(1'b1, 16'd4, 16'd1000, 3'd0);
        step();
        chk("t3_full", 32'(in_ready), 32'(0));
        chk("t3_pipe_after", 32'(dp_pipe), 32'(0));
        drive(1'b1, 16'd5, 16'd1000, 3'd0);
        step();
        chk("t3_ready_again", 32'(in_ready), 32'(1));
        step();
        drive(1'b0, '0, '0, '0);
        chk("t3_first_valid", 32'(out_valid), 32'(1));
        chk("t3_first_Y", 32'(out_Y), 32'(16'd1001));
        wait_idle("t3_drain", 50);
        chk("t3_log_n", 32'(res_log.size()), 32'(6));
        for (int i = 0; i < 6 && i < res_log.size(); i++) begin
            chk("t3_log", 32'(res_log[i][N-1:0]), 32'(exp3[i]));
        end

        // Reset with three queued and two in flight
        pipe_req = 1'b1; drive(1'b1, 16'd7, 16'd1, 3'd0); step();
        pipe_req = 1'b0; drive(1'b1, 16'd8, 16'd1, 3'd1); step();
        pipe_req = 1'b1; drive(1'b1, 16'd9, 16'd1, 3'd2); step();
        drive(1'b1, 16'd10, 16'd1, 3'd3); step();
        drive(1'b1, 16'd11, 16'd1, 3'd4); step();
        drive(1'b0, '0, '0, '0);
        pipe_req = 1'b0;
        chk("t5_busy_pre", 32'(busy), 32'(1));
        chk("t5_dpA_pre", 32'(dp_A), 32'(16'd8));
        rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'(0));
        chk("t5_out_Y", 32'(out_Y), 32'(0));
        chk("t5_out_co", 32'(out_co), 32'(0));
        chk("t5_out_opcode", 32'(out_opcode), 32'(0));
        chk("t5_dp_A", 32'(dp_A), 32'(0));
        chk("t5_dp_B", 32'(dp_B), 32'(0));
        chk("t5_dp_opcode", 32'(dp_opcode), 32'(0));
        chk("t5_dp_pipe", 32'(dp_pipe), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_in_ready", 32'(in_ready), 32'(0));
        step();
        step();
        rst = 1'b0;
        res_log.delete();
        repeat (10) step();
        chk("t5_no_result", 32'(res_log.size()), 32'(0));
        chk("t5_ready_after", 32'(in_ready), 32'(1));
        chk("t5_busy_after", 32'(busy), 32'(0));

        // Random traffic with mode toggles, scoreboarded end to end
        acc_log.delete();
        res_log.delete();
        guard = 0;
        while (acc_log.size() < 100 && guard < 3000) begin
            drive($urandom_range(0, 3) != 0, N'($urandom), N'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 15) == 0) pipe_req = !pipe_req;
            step();
            guard++;
        end
        drive(1'b0, '0, '0, '0);
        chk("rand_pushes", 32'(acc_log.size()), 32'(100));
        wait_idle("rand_drain", 300);
        chk("rand_results", 32'(res_log.size()), 32'(acc_log.size()));
        for (int i = 0; i < acc_log.size() && i < res_log.size(); i++) begin
            r = dp_func(acc_log[i].a, acc_log[i].b, acc_log[i].op);
            chk("rand_sb", 32'(res_log[i]), 32'({acc_log[i].op, r}));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
